cache_bus_arbiter: RTL and testbench

CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

---
 rtl/cache_bus_arbiter.sv | 235 +++++++++++++++++++++++
 tb/tb_cache_bus_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_bus_arbiter.sv
// rtl/cache_bus_arbiter.sv - icache/dcache arbiter onto one memory read port plus a single-entry dcache write buffer
//
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   i_rd_req/type/addr          icache read request (type 000 byte, 001 half, 010 word, 100 line)
//   i_rd_rdy, i_ret_*           icache read grant and return beats
//   d_rd_req/type/addr          dcache read request
//   d_rd_rdy, d_ret_*           dcache read grant and return beats
//   d_wr_req/type/addr/wstrb/data, d_wr_rdy   dcache write into the buffer (rdy = buffer empty)
//   m_rd_*                      shared memory read port (request out, grant/return in)
//   m_wr_*                      shared memory write port (request out, m_wr_rdy in)
//   err                         sticky protocol-error flag
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate between contending readers;
// when undefined the dcache always wins a simultaneous request.
module cache_bus_arbiter #(
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_rd_req,
    input  logic [2:0]        i_rd_type,
    input  logic [31:0]       i_rd_addr,
    output logic              i_rd_rdy,
    output logic              i_ret_valid,
    output logic              i_ret_last,
    output logic [31:0]       i_ret_data,

    input  logic              d_rd_req,
    input  logic [2:0]        d_rd_type,
    input  logic [31:0]       d_rd_addr,
    output logic              d_rd_rdy,
    output logic              d_ret_valid,
    output logic              d_ret_last,
    output logic [31:0]       d_ret_data,

    input  logic              d_wr_req,
    input  logic [2:0]        d_wr_type,
    input  logic [31:0]       d_wr_addr,
    input  logic [3:0]        d_wr_wstrb,
    input  logic [LINE_W-1:0] d_wr_data,
    output logic              d_wr_rdy,

    output logic              m_rd_req,
    output logic [2:0]        m_rd_type,
    output logic [31:0]       m_rd_addr,
    input  logic              m_rd_rdy,
    input  logic              m_ret_valid,
    input  logic              m_ret_last,
    input  logic [31:0]       m_ret_data,

    output logic              m_wr_req,
    output logic [2:0]        m_wr_type,
    output logic [31:0]       m_wr_addr,
    output logic [3:0]        m_wr_wstrb,
    output logic [LINE_W-1:0] m_wr_data,
    input  logic              m_wr_rdy,

    output logic              err
);

    typedef enum logic {R_IDLE = 1'b0, R_BUSY = 1'b1} r_state_t;
    typedef enum logic {W_EMPTY = 1'b0, W_FULL = 1'b1} w_state_t;

    r_state_t          r_state, r_next;
    w_state_t          w_state, w_next;
    logic              owner;        // 0 icache, 1 dcache
    logic [1:0]        beat_cnt;
    logic              rd_is_line;
    logic              err_q;

    logic [2:0]        wb_type;
    logic [31:0]       wb_addr;
    logic [3:0]        wb_wstrb;
    logic [LINE_W-1:0] wb_data;

    logic              w_full;
    logic              i_elig, d_elig, any_elig;
    logic              win_d;
    logic              rd_grant, ret_end, wr_capture;

    assign w_full = (w_state == W_FULL);

    // A read to the line sitting in the write buffer must wait for the drain,
    // otherwise it could return stale memory contents.
    assign i_elig   = i_rd_req && !(w_full && (i_rd_addr[31:4] == wb_addr[31:4]));
    assign d_elig   = d_rd_req && !(w_full && (d_rd_addr[31:4] == wb_addr[31:4]));
    assign any_elig = i_elig || d_elig;

`ifdef ARB_ROUND_ROBIN_EN
    // rr_prefer_i = 1 means the icache wins the next contended cycle; after a
    // grant it points at whichever requester lost.
    logic rr_prefer_i;

    assign win_d = d_elig && !(i_elig && rr_prefer_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_prefer_i <= 1'b0;
        end else if (rd_grant) begin
            rr_prefer_i <= win_d;
        end
    end
`else
    assign win_d = d_elig;
`endif

    assign rd_grant   = !reset && (r_state == R_IDLE) && any_elig && m_rd_rdy;
    assign ret_end    = (r_state == R_BUSY) && m_ret_valid && m_ret_last;
    assign wr_capture = !reset && !w_full && d_wr_req;

    // ---------------- read FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= R_IDLE;
            owner      <= 1'b0;
            beat_cnt   <= 2'd0;
            rd_is_line <= 1'b0;
        end else begin
            r_state <= r_next;
            if (rd_grant) begin
                owner      <= win_d;
                beat_cnt   <= 2'd0;
                rd_is_line <= win_d ? (d_rd_type == 3'b100) : (i_rd_type == 3'b100);
            end else if ((r_state == R_BUSY) && m_ret_valid) begin
                beat_cnt <= beat_cnt + 2'd1;
            end
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (rd_grant) r_next = R_BUSY;
            R_BUSY:  if (ret_end)  r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        i_rd_rdy    = 1'b0;
        d_rd_rdy    = 1'b0;
        m_rd_req    = 1'b0;
        m_rd_type   = 3'd0;
        m_rd_addr   = 32'd0;
        i_ret_valid = 1'b0;
        i_ret_last  = 1'b0;
        i_ret_data  = 32'd0;
        d_ret_valid = 1'b0;
        d_ret_last  = 1'b0;
        d_ret_data  = 32'd0;
        if (!reset) begin
            if (r_state == R_IDLE) begin
                // Beats arriving while idle are stray and go nowhere.
                m_rd_req = any_elig;
                if (win_d) begin
                    m_rd_type = d_rd_type;
                    m_rd_addr = d_rd_addr;
                    d_rd_rdy  = m_rd_rdy;
                end else if (i_elig) begin
                    m_rd_type = i_rd_type;
                    m_rd_addr = i_rd_addr;
                    i_rd_rdy  = m_rd_rdy;
                end
            end else if (owner) begin
                d_ret_valid = m_ret_valid;
                d_ret_last  = m_ret_last;
                d_ret_data  = m_ret_data;
            end else begin
                i_ret_valid = m_ret_valid;
                i_ret_last  = m_ret_last;
                i_ret_data  = m_ret_data;
            end
        end
    end

    // ---------------- error flag ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (m_ret_valid &&
                     ((r_state == R_IDLE) ||
                      (m_ret_last && rd_is_line && (beat_cnt != 2'd3)))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q && !reset;

    // ---------------- write buffer FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state  <= W_EMPTY;
            wb_type  <= 3'd0;
            wb_addr  <= 32'd0;
            wb_wstrb <= 4'd0;
            wb_data  <= '0;
        end else begin
            w_state <= w_next;
            if (wr_capture) begin
                wb_type  <= d_wr_type;
                wb_addr  <= d_wr_addr;
                wb_wstrb <= d_wr_wstrb;
                wb_data  <= d_wr_data;
            end
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_EMPTY: if (wr_capture) w_next = W_FULL;
            W_FULL:  if (m_wr_rdy)   w_next = W_EMPTY;
            default: w_next = W_EMPTY;
        endcase
    end

    always_comb begin
        d_wr_rdy   = reset || !w_full;
        m_wr_req   = 1'b0;
        m_wr_type  = 3'd0;
        m_wr_addr  = 32'd0;
        m_wr_wstrb = 4'd0;
        m_wr_data  = '0;
        if (!reset && w_full) begin
            m_wr_req   = 1'b1;
            m_wr_type  = wb_type;
            m_wr_addr  = wb_addr;
            m_wr_wstrb = wb_wstrb;
            m_wr_data  = wb_data;
        end
    end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb/tb_cache_bus_arbiter.sv - self-checking bench for cache_bus_arbiter
module tb_cache_bus_arbiter;

    localparam int LW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          i_rd_req;
    logic [2:0]    i_rd_type;
    logic [31:0]   i_rd_addr;
    logic          i_rd_rdy, i_ret_valid, i_ret_last;
    logic [31:0]   i_ret_data;
    logic          d_rd_req;
    logic [2:0]    d_rd_type;
    logic [31:0]   d_rd_addr;
    logic          d_rd_rdy, d_ret_valid, d_ret_last;
    logic [31:0]   d_ret_data;
    logic          d_wr_req;
    logic [2:0]    d_wr_type;
    logic [31:0]   d_wr_addr;
    logic [3:0]    d_wr_wstrb;
    logic [LW-1:0] d_wr_data;
    logic          d_wr_rdy;
    logic          m_rd_req;
    logic [2:0]    m_rd_type;
    logic [31:0]   m_rd_addr;
    logic          m_rd_rdy, m_ret_valid, m_ret_last;
    logic [31:0]   m_ret_data;
    logic          m_wr_req;
    logic [2:0]    m_wr_type;
    logic [31:0]   m_wr_addr;
    logic [3:0]    m_wr_wstrb;
    logic [LW-1:0] m_wr_data;
    logic          m_wr_rdy;
    logic          err;

    cache_bus_arbiter #(.LINE_W(LW)) dut (
        .clk(clk), .reset(reset),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
        .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
        .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
        .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
        .m_rd_req(m_rd_req), .m_rd_type(m_rd_type), .m_rd_addr(m_rd_addr),
        .m_rd_rdy(m_rd_rdy), .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last), .m_ret_data(m_ret_data),
        .m_wr_req(m_wr_req), .m_wr_type(m_wr_type), .m_wr_addr(m_wr_addr),
        .m_wr_wstrb(m_wr_wstrb), .m_wr_data(m_wr_data), .m_wr_rdy(m_wr_rdy),
        .err(err)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic          i_rd_rdy, i_ret_valid, i_ret_last;
        logic [31:0]   i_ret_data;
        logic          d_rd_rdy, d_ret_valid, d_ret_last;
        logic [31:0]   d_ret_data;
        logic          d_wr_rdy;
        logic          m_rd_req;
        logic [2:0]    m_rd_type;
        logic [31:0]   m_rd_addr;
        logic          m_wr_req;
        logic [2:0]    m_wr_type;
        logic [31:0]   m_wr_addr;
        logic [3:0]    m_wr_wstrb;
        logic [LW-1:0] m_wr_data;
        logic          err;
    } out_t;

    out_t obs, exp_o;

    // Reference model: one outstanding read transaction, one buffered write.
    logic          mb_busy = 1'b0;
    logic          mb_owner_d = 1'b0;
    int            mb_beats = 0;
    logic          mb_line = 1'b0;
    logic          m_err = 1'b0;
    logic          m_pref_i = 1'b0;
    logic          mw_full = 1'b0;
    logic [2:0]    mw_type = '0;
    logic [31:0]   mw_addr = '0;
    logic [3:0]    mw_wstrb = '0;
    logic [LW-1:0] mw_data = '0;

    function automatic logic blocked(logic [31:0] a);
        return mw_full && (a[31:4] == mw_addr[31:4]);
    endfunction

    function automatic logic pick_d(logic ie, logic de);
`ifdef ARB_ROUND_ROBIN_EN
        if (ie && de) return !m_pref_i;
`endif
        return de;
    endfunction

    function automatic out_t model_out();
        out_t o;
        logic ie, de;
        o  = '0;
        ie = i_rd_req && !blocked(i_rd_addr);
        de = d_rd_req && !blocked(d_rd_addr);
        if (reset) begin
            o.d_wr_rdy = 1'b1;
            return o;
        end
        o.err = m_err;
        if (!mb_busy) begin
            o.m_rd_req = ie || de;
            if (pick_d(ie, de)) begin
                o.m_rd_type = d_rd_type; o.m_rd_addr = d_rd_addr; o.d_rd_rdy = m_rd_rdy;
            end else if (ie) begin
                o.m_rd_type = i_rd_type; o.m_rd_addr = i_rd_addr; o.i_rd_rdy = m_rd_rdy;
            end
        end else if (mb_owner_d) begin
            o.d_ret_valid = m_ret_valid; o.d_ret_last = m_ret_last; o.d_ret_data = m_ret_data;
        end else begin
            o.i_ret_valid = m_ret_valid; o.i_ret_last = m_ret_last; o.i_ret_data = m_ret_data;
        end
        o.d_wr_rdy = !mw_full;
        if (mw_full) begin
            o.m_wr_req = 1'b1; o.m_wr_type = mw_type; o.m_wr_addr = mw_addr;
            o.m_wr_wstrb = mw_wstrb; o.m_wr_data = mw_data;
        end
        return o;
    endfunction

    task automatic model_step();
        logic ie, de, pd;
        if (reset) begin
            mb_busy = 0; mb_owner_d = 0; mb_beats = 0; mb_line = 0;
            m_err = 0; m_pref_i = 0; mw_full = 0; mw_addr = '0;
            return;
        end
        ie = i_rd_req && !blocked(i_rd_addr);
        de = d_rd_req && !blocked(d_rd_addr);
        pd = pick_d(ie, de);
        if (!mb_busy) begin
            if (m_ret_valid) m_err = 1'b1;
            if ((ie || de) && m_rd_rdy) begin
                mb_busy    = 1'b1;
                mb_owner_d = pd;
                mb_beats   = 0;
                mb_line    = ((pd ? d_rd_type : i_rd_type) == 3'b100);
                m_pref_i   = pd;
            end
        end else if (m_ret_valid) begin
            if (m_ret_last) begin
                if (mb_line && (mb_beats % 4) != 3) m_err = 1'b1;
                mb_busy = 1'b0;
            end
            mb_beats++;
        end
        if (!mw_full) begin
            if (d_wr_req) begin
                mw_full = 1'b1; mw_type = d_wr_type; mw_addr = d_wr_addr;
                mw_wstrb = d_wr_wstrb; mw_data = d_wr_data;
            end
        end else if (m_wr_rdy) begin
            mw_full = 1'b0;
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // One clock: sample at the falling edge, compare with the model, advance.
    task automatic eval();
        @(negedge clk);
        obs = {i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
               d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
               d_wr_rdy, m_rd_req, m_rd_type, m_rd_addr,
               m_wr_req, m_wr_type, m_wr_addr, m_wr_wstrb, m_wr_data, err};
        exp_o = model_out();
        tests++;
        if (obs !== exp_o) begin
            fails++;
            $display("FAIL model: got %h expected %h", obs, exp_o);
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
        d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
        d_wr_req = 0; d_wr_type = 0; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = '0;
        m_rd_rdy = 0; m_ret_valid = 0; m_ret_last = 0; m_ret_data = 0; m_wr_rdy = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        eval();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [31:0] rst, ireq, dreq, mrdy, rv, rl, rdata;
        logic [31:0] e_mreq, e_maddr, e_irdy, e_drdy, e_iv, e_dv, e_dl, e_err;
    } vec_t;

    vec_t vt[12];

    logic [2:0]  rtypes[4];
    logic [31:0] rbases[4];

    initial begin
        reset = 1'b1;
        idle_inputs();

        //         rst ireq dreq mrdy rv rl rdata     mreq maddr      irdy drdy iv dv dl err
        vt[0]  = '{1, 1, 1, 1, 0, 0, 0,          0, 0,          0, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 1, 1, 1, 0, 0, 0,          1, 32'h2000,   0, 1, 0, 0, 0, 0};
        vt[2]  = '{0, 1, 0, 1, 1, 0, 32'h11,     0, 0,          0, 0, 0, 1, 0, 0};
        vt[3]  = '{0, 1, 0, 1, 1, 0, 32'h12,     0, 0,          0, 0, 0, 1, 0, 0};
        vt[4]  = '{0, 1, 0, 1, 1, 0, 32'h13,     0, 0,          0, 0, 0, 1, 0, 0};
        vt[5]  = '{0, 1, 0, 1, 1, 1, 32'h14,     0, 0,          0, 0, 0, 1, 1, 0};
        vt[6]  = '{0, 1, 0, 1, 0, 0, 0,          1, 32'h1000,   1, 0, 0, 0, 0, 0};
        vt[7]  = '{0, 0, 0, 1, 1, 1, 32'h21,     0, 0,          0, 0, 1, 0, 0, 0};
        vt[8]  = '{0, 0, 0, 1, 0, 0, 0,          0, 0,          0, 0, 0, 0, 0, 1};
        vt[9]  = '{0, 0, 0, 1, 1, 0, 32'h31,     0, 0,          0, 0, 0, 0, 0, 1};
        vt[10] = '{1, 0, 0, 0, 0, 0, 0,          0, 0,          0, 0, 0, 0, 0, 0};
        vt[11] = '{0, 0, 0, 0, 0, 0, 0,          0, 0,          0, 0, 0, 0, 0, 0};

        // Contended line reads, dcache first, icache after the last beat,
        // then a short icache line read that raises err.
        i_rd_type = 3'b100; i_rd_addr = 32'h1000;
        d_rd_type = 3'b100; d_rd_addr = 32'h2000;
        for (int k = 0; k < 12; k++) begin
            reset       = vt[k].rst[0];
            i_rd_req    = vt[k].ireq[0];
            d_rd_req    = vt[k].dreq[0];
            m_rd_rdy    = vt[k].mrdy[0];
            m_ret_valid = vt[k].rv[0];
            m_ret_last  = vt[k].rl[0];
            m_ret_data  = vt[k].rdata;
            eval();
            check($sformatf("tbl%0d_m_rd_req", k), 32'(obs.m_rd_req), vt[k].e_mreq);
            check($sformatf("tbl%0d_m_rd_addr", k), obs.m_rd_addr, vt[k].e_maddr);
            check($sformatf("tbl%0d_i_rd_rdy", k), 32'(obs.i_rd_rdy), vt[k].e_irdy);
            check($sformatf("tbl%0d_d_rd_rdy", k), 32'(obs.d_rd_rdy), vt[k].e_drdy);
            check($sformatf("tbl%0d_i_ret_valid", k), 32'(obs.i_ret_valid), vt[k].e_iv);
            check($sformatf("tbl%0d_d_ret_valid", k), 32'(obs.d_ret_valid), vt[k].e_dv);
            check($sformatf("tbl%0d_d_ret_last", k), 32'(obs.d_ret_last), vt[k].e_dl);
            check($sformatf("tbl%0d_err", k), 32'(obs.err), vt[k].e_err);
            if (vt[k].e_dv[0])
                check($sformatf("tbl%0d_d_ret_data", k), obs.d_ret_data, vt[k].rdata);
        end

        // Read to a line held in the write buffer waits for the drain.
        do_reset();
        d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h3000; d_wr_wstrb = 4'hF;
        d_wr_data = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};
        eval();
        check("raw_capture_rdy", 32'(obs.d_wr_rdy), 32'd1);
        check("raw_capture_no_mwr", 32'(obs.m_wr_req), 32'd0);
        d_wr_req = 0; d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'h3004; m_rd_rdy = 1;
        for (int c = 0; c < 5; c++) begin
            eval();
            check("raw_blocked_m_rd_req", 32'(obs.m_rd_req), 32'd0);
            check("raw_full_d_wr_rdy", 32'(obs.d_wr_rdy), 32'd0);
            check("raw_full_m_wr_req", 32'(obs.m_wr_req), 32'd1);
            check("raw_full_m_wr_addr", obs.m_wr_addr, 32'h3000);
        end
        m_wr_rdy = 1;
        eval();
        check("raw_drain_m_rd_req", 32'(obs.m_rd_req), 32'd0);
        m_wr_rdy = 0;
        eval();
        check("raw_after_m_rd_req", 32'(obs.m_rd_req), 32'd1);
        check("raw_after_m_rd_addr", obs.m_rd_addr, 32'h3004);
        check("raw_after_d_wr_rdy", 32'(obs.d_wr_rdy), 32'd1);

        // icache line read with four in-order beats.
        do_reset();
        i_rd_req = 1; i_rd_type = 3'b100; i_rd_addr = 32'h1000; m_rd_rdy = 1;
        eval();
        check("iline_grant", 32'(obs.i_rd_rdy), 32'd1);
        i_rd_req = 0;
        for (int b = 0; b < 4; b++) begin
            m_ret_valid = 1; m_ret_data = 32'hA + 32'(b); m_ret_last = (b == 3);
            eval();
            check("iline_valid", 32'(obs.i_ret_valid), 32'd1);
            check("iline_data", obs.i_ret_data, 32'hA + 32'(b));
            check("iline_last", 32'(obs.i_ret_last), 32'(b == 3));
            check("iline_d_quiet", 32'(obs.d_ret_valid), 32'd0);
        end
        m_ret_valid = 0; m_ret_last = 0;
        eval();
        check("iline_err", 32'(obs.err), 32'd0);

        // Reset while a read is outstanding and the buffer is full.
        do_reset();
        d_rd_req = 1; d_rd_type = 3'b100; d_rd_addr = 32'h2000; m_rd_rdy = 1;
        d_wr_req = 1; d_wr_type = 3'b100; d_wr_addr = 32'h5000; d_wr_wstrb = 4'h3;
        eval();
        check("rst_grant", 32'(obs.d_rd_rdy), 32'd1);
        check("rst_capture", 32'(obs.d_wr_rdy), 32'd1);
        d_rd_req = 0; d_wr_req = 0; m_rd_rdy = 0;
        eval();
        check("rst_full", 32'(obs.m_wr_req), 32'd1);
        reset = 1;
        eval();
        check("rst_during_m_rd_req", 32'(obs.m_rd_req), 32'd0);
        check("rst_during_m_wr_req", 32'(obs.m_wr_req), 32'd0);
        check("rst_during_d_wr_rdy", 32'(obs.d_wr_rdy), 32'd1);
        reset = 0;
        eval();
        check("rst_after_m_wr_req", 32'(obs.m_wr_req), 32'd0);
        check("rst_after_d_wr_rdy", 32'(obs.d_wr_rdy), 32'd1);
        m_ret_valid = 1; m_ret_data = 32'h55;
        eval();
        check("rst_stray_d", 32'(obs.d_ret_valid), 32'd0);
        check("rst_stray_i", 32'(obs.i_ret_valid), 32'd0);
        m_ret_valid = 0;
        eval();
        check("rst_stray_err", 32'(obs.err), 32'd1);

`ifdef ARB_ROUND_ROBIN_EN
        // Back-to-back contended reads alternate d, i, d.
        do_reset();
        i_rd_req = 1; i_rd_type = 3'b010; i_rd_addr = 32'h1000;
        d_rd_req = 1; d_rd_type = 3'b010; d_rd_addr = 32'h2000; m_rd_rdy = 1;
        for (int g = 0; g < 3; g++) begin
            eval();
            check("rr_d_grant", 32'(obs.d_rd_rdy), 32'(g != 1));
            check("rr_i_grant", 32'(obs.i_rd_rdy), 32'(g == 1));
            m_ret_valid = 1; m_ret_last = 1;
            eval();
            m_ret_valid = 0; m_ret_last = 0;
        end
`endif

        // Randomized traffic against the model.
        rtypes = '{3'b000, 3'b001, 3'b010, 3'b100};
        rbases = '{32'h3000, 32'h3010, 32'h4000, 32'h1000};
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(149) == 0);
            i_rd_req    = ($urandom_range(1) == 1);
            i_rd_type   = rtypes[$urandom_range(3)];
            i_rd_addr   = rbases[$urandom_range(3)] | 32'($urandom_range(15));
            d_rd_req    = ($urandom_range(1) == 1);
            d_rd_type   = rtypes[$urandom_range(3)];
            d_rd_addr   = rbases[$urandom_range(3)] | 32'($urandom_range(15));
            d_wr_req    = ($urandom_range(2) == 0);
            d_wr_type   = rtypes[$urandom_range(3)];
            d_wr_addr   = rbases[$urandom_range(3)] | 32'($urandom_range(15));
            d_wr_wstrb  = 4'($urandom);
            d_wr_data   = {$urandom, $urandom, $urandom, $urandom};
            m_rd_rdy    = ($urandom_range(1) == 1);
            m_ret_valid = ($urandom_range(1) == 1);
            m_ret_last  = ($urandom_range(3) == 0);
            m_ret_data  = $urandom;
            m_wr_rdy    = ($urandom_range(2) == 0);
            eval();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
